// File: rtl/debounce_sync_if.sv
// Signal bundle between a raw level source (master) and debounce_sync (slave).
// glitch_cnt is present only when DEBOUNCE_GLITCH_CNT_EN is defined.
interface debounce_sync_if;
    logic din;
    logic q;
    logic rise;
    logic fall;
    logic busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;

    modport master (output din, input q, rise, fall, busy, glitch_cnt);
    modport slave  (input din, output q, rise, fall, busy, glitch_cnt);
`else
    modport master (output din, input q, rise, fall, busy);
    modport slave  (input din, output q, rise, fall, busy);
`endif
endinterface

// File: rtl/debounce_sync.sv
// Synchroniser plus stability-qualified debouncer with registered level and edge pulses.
// Define DEBOUNCE_GLITCH_CNT_EN to add the saturating rejected-change counter (glitch_cnt).
module debounce_sync #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    debounce_sync_if.slave bus
);
    typedef enum logic [1:0] {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} state_t;

    localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);
    localparam bit         SINGLE   = (STABLE_CYCLES == 1);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   s;
    state_t                 state;
    state_t                 next_state;
    logic [7:0]             cnt;
    logic [7:0]             next_cnt;
    logic                   accept_hi;
    logic                   accept_lo;
    logic                   q_r;
    logic                   rise_r;
    logic                   fall_r;
    logic                   busy_r;

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) sync_ff <= '0;
        else          sync_ff <= {sync_ff[SYNC_STAGES-2:0], bus.din};
    end

    assign s = sync_ff[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= STABLE_LO;
            cnt    <= '0;
            q_r    <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            state  <= next_state;
            cnt    <= next_cnt;
            rise_r <= accept_hi;
            fall_r <= accept_lo;
            busy_r <= (next_state == CHK_HI) || (next_state == CHK_LO);
            if (accept_hi)      q_r <= 1'b1;
            else if (accept_lo) q_r <= 1'b0;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        next_state = state;
        next_cnt   = cnt;
        case (state)
            STABLE_LO: begin
                if (s) begin
                    if (SINGLE) begin
                        next_state = STABLE_HI;
                    end else begin
                        next_state = CHK_HI;
                        next_cnt   = 8'd1;
                    end
                end
            end
            CHK_HI: begin
                if (!s)                   next_state = STABLE_LO;
                else if (cnt == LAST_CNT) next_state = STABLE_HI;
                else                      next_cnt   = cnt + 8'd1;
            end
            STABLE_HI: begin
                if (!s) begin
                    if (SINGLE) begin
                        next_state = STABLE_LO;
                    end else begin
                        next_state = CHK_LO;
                        next_cnt   = 8'd1;
                    end
                end
            end
            CHK_LO: begin
                if (s)                    next_state = STABLE_HI;
                else if (cnt == LAST_CNT) next_state = STABLE_LO;
                else                      next_cnt   = cnt + 8'd1;
            end
            default: next_state = STABLE_LO;
        endcase
    end

    // Acceptance is a move into the opposite stable state; aborts return to the origin.
    always_comb begin
        accept_hi = (next_state == STABLE_HI) && ((state == STABLE_LO) || (state == CHK_HI));
        accept_lo = (next_state == STABLE_LO) && ((state == STABLE_HI) || (state == CHK_LO));
    end

    assign bus.q    = q_r;
    assign bus.rise = rise_r;
    assign bus.fall = fall_r;
    assign bus.busy = busy_r;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic       glitch;
    logic [7:0] glitch_cnt_r;

    always_comb begin
        glitch = ((state == CHK_HI) && (next_state == STABLE_LO)) ||
                 ((state == CHK_LO) && (next_state == STABLE_HI));
    end

    always_ff @(posedge clk) begin
        if (!reset_n)                            glitch_cnt_r <= '0;
        else if (glitch && glitch_cnt_r != 8'hFF) glitch_cnt_r <= glitch_cnt_r + 8'd1;
    end

    assign bus.glitch_cnt = glitch_cnt_r;
`endif
endmodule

// File: doc/debounce_sync.md
# debounce_sync

Input conditioning stage that sits directly upstream of the team's synchronous-reset D flip-flop stages. It takes an asynchronous, possibly bouncing, raw input (button, strap, external level) and synchronises it into the `clk` domain. It then accepts a level change only after the input has been stable for a programmable number of cycles, and presents a clean registered level plus single-cycle rise/fall pulses. The clean level is intended to drive the `d` input of downstream flops directly.

## Interface
- `SYNC_STAGES`, 2, number of synchroniser flops; legal range 2..4.
- `STABLE_CYCLES`, 4, number of consecutive equal synchronised samples required to accept a change; legal range 1..255.
- `clk` input 1: clock; all logic is rising-edge.
- `reset_n` input 1: reset, synchronous, active-low.
- `din` input 1: raw asynchronous input; may bounce.
- `q` output 1: debounced level, registered.
- `rise` output 1: one-cycle pulse when `q` goes 0→1.
- `fall` output 1: one-cycle pulse when `q` goes 1→0.
- `busy` output 1: high while a candidate change is being qualified (states CHK_HI and CHK_LO).
- `glitch_cnt` output 8: rejected-change counter; present only with `DEBOUNCE_GLITCH_CNT_EN`.

## Operation
- Reset (`reset_n`=0 at a rising edge):
  - all synchroniser flops are cleared to 0, and `cnt` is cleared to 0;
  - state goes to STABLE_LO;
  - `q`, `rise`, `fall`, `busy`, `glitch_cnt` are all 0.
- `s` is the output of the last synchroniser stage. The FSM never samples `din` directly.
- FSM states: STABLE_LO, CHK_HI, STABLE_HI, CHK_LO. 8-bit counter `cnt`.
- STABLE_LO:
  - `s`=1 and `STABLE_CYCLES`=1: go to STABLE_HI; set `q`=1 and `rise`=1.
  - `s`=1 and `STABLE_CYCLES`>1: go to CHK_HI with `cnt`=1.
  - `s`=0: stay.
- CHK_HI:
  - `s`=0: go back to STABLE_LO; count a glitch.
  - `s`=1 and `cnt`==`STABLE_CYCLES`-1: go to STABLE_HI; set `q`=1 and `rise`=1.
  - otherwise: increment `cnt`.
- STABLE_HI and CHK_LO mirror the above with polarity inverted. Acceptance drives `q`=0 and `fall`=1.
- `rise` and `fall` are high for exactly one cycle, in the same cycle `q` changes. They are never high simultaneously.
- `q` changes only on acceptance and never toggles while in a CHK state.
- A glitch is any abort from CHK_HI or CHK_LO back to the originating stable state.
- `busy` is a registered decode of the next state (CHK_HI or CHK_LO), so it is aligned with the state register.

## Timing
- Latency from a clean `din` edge (set up before edge E1) to the `q` change:
  - edge count = `SYNC_STAGES` + `STABLE_CYCLES`;
  - with defaults, `q` changes after E6, and `rise` is high for the cycle following E6.
- `s` becoming 1 first affects the FSM at the edge after the last synchroniser stage captures it.
- Minimum accepted pulse width on `din`: `STABLE_CYCLES` clock periods. Shorter pulses never reach `q`.
- Reset mid-qualification: the CHK state and `cnt` are abandoned and `q`=0. If `din` is still 1 after `reset_n` returns high, the full latency applies and `rise` fires once.
- Reset while in STABLE_HI: `q` drops to 0 without a `fall` pulse.
- Back-to-back accepted changes are separated by at least `STABLE_CYCLES` cycles.

## Configuration
- `DEBOUNCE_GLITCH_CNT_EN` defined:
  - the `glitch_cnt` port and its 8-bit saturating counter exist;
  - the counter increments by 1 on every glitch and holds at 255;
  - it is cleared only by reset.
- `DEBOUNCE_GLITCH_CNT_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Defaults; reset, then `din`=1 held: `q`=0 through E5, `q`=1 after E6, `rise`=1 for exactly one cycle, `busy`=1 during qualification.
- Defaults; from stable `q`=1, `din` low for 3 cycles then high: `q` stays 1, no `fall`, `busy` returns to 0, `glitch_cnt`=1.
- Defaults; bounce `din` 1,0,1,0 at 1-cycle intervals, then hold 1 for 10 cycles: exactly one `rise`, `q`=1 at the end, `glitch_cnt` ≥ 1.
- `STABLE_CYCLES`=1, `SYNC_STAGES`=2; single-cycle `din`=1 pulse: `q` pulses high for one cycle with `rise` then `fall`.
- Reset asserted at qualification count 3 with `din`=1 held, then released: `q`=0 during reset, `q`=1 exactly 6 edges after release, single `rise`.
- With the macro, 300 rejected glitches: `glitch_cnt` saturates at 255. Then reset: `glitch_cnt`=0.
